// File: rtl/user_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : user_uart_tx
// Description : UART transmitter with a small transmit FIFO. Bytes are queued
//               through a valid/ready handshake and sent as 8N1 frames (start,
//               8 data bits LSB first, stop). Each bit is held for
//               clk_div+1 clock cycles, with clk_div latched at frame start.
//               Frames are sent back-to-back while the FIFO holds data.
//               Define USER_UART_TX_PARITY_EN to insert an even-parity bit
//               between the data bits and the stop bit (11-bit frame).
// Ports       : wb_clk_i   - clock, rising edge
//               wb_rst_i   - synchronous active-high reset
//               in_data    - byte to transmit
//               in_valid   - in_data valid
//               in_ready   - FIFO can accept a byte
//               clk_div    - bit period minus one, in clock cycles
//               tx         - serial line, idle high (registered)
//               busy       - frame in progress or FIFO non-empty
//               fifo_level - current FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module user_uart_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [15:0]                     clk_div,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W  = c_ADDR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(FIFO_DEPTH);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
`ifdef USER_UART_TX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [15:0]         r_div;
    logic [15:0]         r_tick;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_tx;
    logic                w_tx_next;
    logic                w_load;
    logic                w_push;
    logic                w_fifo_empty;
    logic                w_bit_done;
`ifdef USER_UART_TX_PARITY_EN
    logic                r_parity;
`endif

    assign w_fifo_empty = (r_level == '0);
    // Derived from the registered level only, so a same-cycle pop never
    // lets a push through while full.
    assign in_ready     = (r_level != c_FULL);
    assign w_push       = in_valid && in_ready;
    assign w_bit_done   = (r_tick == r_div);

    assign tx         = r_tx;
    assign busy       = (r_state != c_IDLE) || !w_fifo_empty;
    assign fifo_level = r_level;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (!w_fifo_empty) w_state_next = c_START;
            end
            c_START: begin
                if (w_bit_done) w_state_next = c_DATA;
            end
            c_DATA: begin
                if (w_bit_done && (r_bit_cnt == 3'd7)) begin
`ifdef USER_UART_TX_PARITY_EN
                    w_state_next = c_PARITY;
`else
                    w_state_next = c_STOP;
`endif
                end
            end
`ifdef USER_UART_TX_PARITY_EN
            c_PARITY: begin
                if (w_bit_done) w_state_next = c_STOP;
            end
`endif
            c_STOP: begin
                // Chain straight into the next frame when data is waiting.
                if (w_bit_done) w_state_next = w_fifo_empty ? c_IDLE : c_START;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: the value tx takes after the coming edge, plus the
    // FIFO pop / frame load strobe.
    // ------------------------------------------------------------------
    always_comb begin
        w_load    = (r_state != c_START) && (w_state_next == c_START);
        w_tx_next = r_tx;
        if (r_state != w_state_next) begin
            case (w_state_next)
                c_START:  w_tx_next = 1'b0;
                c_DATA:   w_tx_next = r_shift[0];
`ifdef USER_UART_TX_PARITY_EN
                c_PARITY: w_tx_next = r_parity;
`endif
                default:  w_tx_next = 1'b1;
            endcase
        end else if ((r_state == c_DATA) && w_bit_done) begin
            // Shifter moves right at the same edge, so bit 1 is next.
            w_tx_next = r_shift[1];
        end
    end

    // ------------------------------------------------------------------
    // Bit timing, shifter and line register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tx      <= 1'b1;
            r_tick    <= '0;
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
`ifdef USER_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_tx <= w_tx_next;
            if (w_load) begin
                r_shift   <= r_mem[r_rd_ptr];
                r_div     <= clk_div;
                r_tick    <= '0;
                r_bit_cnt <= '0;
`ifdef USER_UART_TX_PARITY_EN
                r_parity  <= ^r_mem[r_rd_ptr];
`endif
            end else if (r_state != c_IDLE) begin
                if (w_bit_done) begin
                    r_tick <= '0;
                    if (r_state == c_DATA) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end else begin
                    r_tick <= r_tick + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            if (w_load) r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            case ({w_push, w_load})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_user_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_uart_tx
// Description : Self-checking bench for user_uart_tx. A reference model keeps
//               the queued bytes and the per-cycle line waveform of the frame
//               in flight; every cycle tx, fifo_level, busy and in_ready are
//               compared against it. Directed scenarios are followed by a
//               randomized traffic phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_uart_tx;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   clk_div;
    logic          tx;
    logic          busy;
    logic [LW-1:0] fifo_level;

    int checks   = 0;
    int failures = 0;

    byte unsigned mq[$];   // bytes accepted but not yet started
    bit           sq[$];   // remaining line values of the frame in flight
    bit           exp_tx   = 1'b1;
    bit           exp_busy = 1'b0;
    bit           last_acc = 1'b0;

    user_uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .clk_div    (clk_div),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Line waveform of one frame, one entry per clock cycle.
    function automatic void build_frame(byte unsigned b, int div);
        bit par;
        par = ^b;
        repeat (div + 1) sq.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (div + 1) sq.push_back(b[i]);
        end
`ifdef USER_UART_TX_PARITY_EN
        repeat (div + 1) sq.push_back(par);
`else
        if (par) begin end
`endif
        repeat (div + 1) sq.push_back(1'b1);
    endfunction

    task automatic check1(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: update the model with the inputs seen at this edge, then
    // compare the DUT outputs just after the edge.
    task automatic step();
        bit acc;
        bit in_frame;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            sq.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            last_acc = 1'b0;
        end else begin
            acc = in_valid && (mq.size() != DEPTH);
            if (sq.size() == 0 && mq.size() != 0) build_frame(mq.pop_front(), int'(clk_div));
            in_frame = (sq.size() != 0);
            exp_tx   = in_frame ? sq.pop_front() : 1'b1;
            if (acc) mq.push_back(in_data);
            exp_busy = in_frame || (mq.size() != 0);
            last_acc = acc;
        end
        #1;
        check1("tx",         32'(tx),         32'(exp_tx));
        check1("fifo_level", 32'(fifo_level), 32'(mq.size()));
        check1("busy",       32'(busy),       32'(exp_busy));
        check1("in_ready",   32'(in_ready),   32'(mq.size() != DEPTH));
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    // Holds in_valid with the byte until the model accepts it.
    task automatic push_byte(byte unsigned b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            step();
            n++;
        end while (!last_acc && n < 1000);
        checks++;
        assert (last_acc) else begin
            failures++;
            $error("FAIL push_timeout observed=%0d cycles expected=accept byte %0h", n, b);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset with in_valid asserted: the byte must be ignored.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        clk_div  = 16'd0;
        step();
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(2);

        // Single byte, 4-cycle bits.
        clk_div = 16'd3;
        push_byte(8'hA5);
        idle(45);

        // Back-to-back frames with no idle gap.
        clk_div = 16'd1;
        push_byte(8'h55);
        push_byte(8'hAB);
        idle(45);

        // Fill the FIFO with in_valid held.
        clk_div = 16'd9;
        for (int i = 0; i < 6; i++) push_byte(byte'(i));
        check1("full_level", 32'(fifo_level), 32'(DEPTH));
        idle(600);

        // Reset during data bit 3 with two bytes queued.
        clk_div = 16'd3;
        push_byte(8'h0F);
        push_byte(8'h11);
        push_byte(8'h22);
        idle(17);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(60);

        // Parity values (checked against the frame length of the build).
        clk_div = 16'd0;
        push_byte(8'h07);
        idle(14);
        push_byte(8'h03);
        idle(14);

        // Divisor change mid-frame.
        clk_div = 16'd3;
        push_byte(8'h3C);
        push_byte(8'hC3);
        idle(10);
        clk_div = 16'd7;
        idle(150);

        // Randomized traffic.
        for (int c = 0; c < 500; c++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = 8'($urandom);
            if ($urandom_range(0, 40) == 0) clk_div = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 300) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
        end
        in_valid = 1'b0;
        idle(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
